// File: rtl/div_pkg.sv
// div_pkg: shared states, counter sizing and divide-by-zero constant for restoring_div_nxn.
package div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int N_DEF = 16;
    localparam int CNT_W = $clog2(N_DEF + 1);
    localparam logic [63:0] DIV_ZERO_Q = '1;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one restoring iteration; shifts the next dividend bit into the partial remainder
// and subtracts the divisor when it fits.
module div_step import div_pkg::*; #(
    parameter int n = N_DEF
) (
    input  logic [n-1:0] pr_i,
    input  logic         bit_i,
    input  logic [n-1:0] dvs_i,
    output logic [n-1:0] pr_o,
    output logic         q_o
);

    logic [n:0] sh;
    logic [n:0] t;

    // Kept at n+1 bits so a partial remainder above 2^(n-1) does not lose its carry-out.
    assign sh   = {pr_i, bit_i};
    assign t    = sh - {1'b0, dvs_i};
    assign q_o  = ~t[n];
    assign pr_o = q_o ? t[n-1:0] : sh[n-1:0];

endmodule

// File: rtl/restoring_div_nxn.sv
// restoring_div_nxn: sequential shift-subtract divider, one quotient bit per clock, MSB first.
// Define SIGNED_DIV_EN for two's-complement operands (truncating toward zero).
module restoring_div_nxn import div_pkg::*; #(
    parameter int n = N_DEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [n-1:0] data0_i,
    input  logic [n-1:0] data1_i,
    output logic [n-1:0] q_o,
    output logic [n-1:0] r_o,
    output logic         busy_o,
    output logic         fl_o,
    output logic         dz_o
);

    localparam int CW = cnt_w(n);

    state_t         state_q, state_d;
    logic [2*n-1:0] acc_q, acc_d;
    logic [n-1:0]   dvs_q, dvs_d;
    logic [n-1:0]   q_q, q_d;
    logic [n-1:0]   r_q, r_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           fl_q, fl_d;
    logic           dz_q, dz_d;
    logic [n-1:0]   a_mag, d_mag;
    logic [n-1:0]   pr_nx, q_fin, r_fin;
    logic           qb;
    logic [2*n-1:0] acc_nx;

    div_step #(.n(n)) u_step (
        .pr_i  (acc_q[2*n-1:n]),
        .bit_i (acc_q[n-1]),
        .dvs_i (dvs_q),
        .pr_o  (pr_nx),
        .q_o   (qb)
    );

    assign acc_nx = {pr_nx, acc_q[n-2:0], qb};

`ifdef SIGNED_DIV_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;

    assign a_mag = data0_i[n-1] ? -data0_i : data0_i;
    assign d_mag = data1_i[n-1] ? -data1_i : data1_i;
    // Sign fix-up rides on the final step so DONE entry keeps the unsigned latency.
    assign q_fin = qneg_q ? -acc_nx[n-1:0] : acc_nx[n-1:0];
    assign r_fin = rneg_q ? -acc_nx[2*n-1:n] : acc_nx[2*n-1:n];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end

    always_comb begin
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        if (state_q != CALC && start_i) begin
            qneg_d = data0_i[n-1] ^ data1_i[n-1];
            rneg_d = data0_i[n-1];
        end
    end
`else
    assign a_mag = data0_i;
    assign d_mag = data1_i;
    assign q_fin = acc_nx[n-1:0];
    assign r_fin = acc_nx[2*n-1:n];
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            fl_q    <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            fl_q    <= fl_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        fl_d    = fl_q;
        dz_d    = dz_q;
        if (state_q != CALC && start_i) begin
            fl_d = 1'b0;
            dz_d = 1'b0;
            if (data1_i == '0) begin
                state_d = DONE;
                q_d     = DIV_ZERO_Q[n-1:0];
                r_d     = data0_i;
                fl_d    = 1'b1;
                dz_d    = 1'b1;
            end else begin
                state_d = CALC;
                dvs_d   = d_mag;
                acc_d   = {{n{1'b0}}, a_mag};
                cnt_d   = CW'(n);
            end
        end else if (state_q == CALC) begin
            acc_d = acc_nx;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                state_d = DONE;
                q_d     = q_fin;
                r_d     = r_fin;
                fl_d    = 1'b1;
            end
        end
    end

    assign q_o    = q_q;
    assign r_o    = r_q;
    assign busy_o = (state_q == CALC);
    assign fl_o   = fl_q;
    assign dz_o   = dz_q;

endmodule

// File: tb/tb_restoring_div_nxn.sv
// tb_restoring_div_nxn: directed vector table plus handshake corner-case sequences.
module tb_restoring_div_nxn;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] data0 = '0;
    logic [15:0] data1 = '0;
    logic [15:0] q, r;
    logic        busy, fl, dz;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    restoring_div_nxn #(.n(16)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .data0_i (data0),
        .data1_i (data1),
        .q_o     (q),
        .r_o     (r),
        .busy_o  (busy),
        .fl_o    (fl),
        .dz_o    (dz)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] eq;
        logic [15:0] er;
        logic        edz;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Pulses start for one cycle, scrambles operands afterwards and counts busy cycles until fl_o.
    task automatic run(input logic [15:0] a, input logic [15:0] d, output int bcnt, output int fcyc);
        @(negedge clk);
        data0 = a;
        data1 = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        data0 = 16'h5A5A;
        data1 = 16'h0003;
        bcnt = 0;
        fcyc = 0;
        for (int c = 1; c <= 40; c++) begin
            if (busy) bcnt++;
            if (fl) begin
                fcyc = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    vec_t vt[$];
    int   bc, fc;

    initial begin
`ifdef SIGNED_DIV_EN
        vt.push_back('{16'd100,  16'd7,    16'd14,   16'd2,    1'b0});
        vt.push_back('{16'hFFF9, 16'd2,    16'hFFFD, 16'hFFFF, 1'b0});
        vt.push_back('{16'd7,    16'hFFFE, 16'hFFFD, 16'd1,    1'b0});
        vt.push_back('{16'hFFF9, 16'hFFFE, 16'd3,    16'hFFFF, 1'b0});
        vt.push_back('{16'h8000, 16'hFFFF, 16'h8000, 16'd0,    1'b0});
        vt.push_back('{16'h8000, 16'd1,    16'h8000, 16'd0,    1'b0});
        vt.push_back('{16'h7FFF, 16'h8000, 16'd0,    16'h7FFF, 1'b0});
        vt.push_back('{16'hFFFB, 16'd0,    16'hFFFF, 16'hFFFB, 1'b1});
        vt.push_back('{16'd5,    16'd0,    16'hFFFF, 16'd5,    1'b1});
`else
        vt.push_back('{16'd100,  16'd7,    16'd14,   16'd2,    1'b0});
        vt.push_back('{16'hFFFF, 16'hFFFF, 16'd1,    16'd0,    1'b0});
        vt.push_back('{16'hFFFE, 16'hFFFF, 16'd0,    16'hFFFE, 1'b0});
        vt.push_back('{16'hFFFF, 16'h8001, 16'd1,    16'h7FFE, 1'b0});
        vt.push_back('{16'h8000, 16'h00FF, 16'h0080, 16'h0080, 1'b0});
        vt.push_back('{16'd0,    16'd5,    16'd0,    16'd0,    1'b0});
        vt.push_back('{16'd1000, 16'd3,    16'd333,  16'd1,    1'b0});
        vt.push_back('{16'd5,    16'd0,    16'hFFFF, 16'd5,    1'b1});
`endif
        repeat (2) @(negedge clk);
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_flags", {busy, fl, dz}, 0);
        rst = 1'b0;

        foreach (vt[i]) begin
            run(vt[i].a, vt[i].d, bc, fc);
            check($sformatf("v%0d_q", i), q, vt[i].eq);
            check($sformatf("v%0d_r", i), r, vt[i].er);
            check($sformatf("v%0d_dz", i), dz, vt[i].edz);
            check($sformatf("v%0d_busy_cycles", i), bc, vt[i].edz ? 0 : 16);
            check($sformatf("v%0d_fl_cycle", i), fc, vt[i].edz ? 1 : 17);
        end

        repeat (3) @(negedge clk);
        check("hold_fl", fl, 1);
        check("hold_q", q, vt[vt.size()-1].eq);

        // Start held high: second job accepted on the edge after the first completes.
        @(negedge clk);
        data0 = 16'hFFFF;
        data1 = 16'd1;
        start = 1'b1;
        for (int j = 0; j < 2; j++) begin
            fc = 0;
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                if (fl) begin
                    fc = c;
                    break;
                end
            end
            check($sformatf("b2b%0d_cycle", j), fc, 17);
            check($sformatf("b2b%0d_q", j), q, j == 0 ? 16'hFFFF : 16'd0);
            check($sformatf("b2b%0d_r", j), r, j == 0 ? 16'd0 : 16'd3);
            data0 = 16'd3;
            data1 = 16'd10;
        end
        start = 1'b0;
        @(negedge clk);

        // A start pulse while busy is ignored.
        data0 = 16'd1000;
        data1 = 16'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        data0 = 16'd9;
        data1 = 16'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fc = 0;
        for (int c = 6; c <= 40; c++) begin
            if (fl) begin
                fc = c;
                break;
            end
            @(negedge clk);
        end
        check("ign_cycle", fc, 17);
        check("ign_q", q, 333);
        check("ign_r", r, 1);
        @(negedge clk);
        check("ign_stays_done", {busy, fl}, 2'b01);

        // Asynchronous reset mid-calculation.
        data0 = 16'hABCD;
        data1 = 16'h0012;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("arst_q", q, 0);
        check("arst_r", r, 0);
        check("arst_flags", {busy, fl, dz}, 0);
        @(negedge clk);
        rst = 1'b0;
        run(16'd50, 16'd5, bc, fc);
        check("post_rst_q", q, 10);
        check("post_rst_r", r, 0);
        check("post_rst_cycle", fc, 17);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
